// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered round-robin arbiter with valid/ready grant handshake
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   requests[WIDTH]        request level per requester
//   lock                   (only with ROUND_ROBIN_ARBITER_LOCK_EN) reissue grant to a still-requesting owner
//   grant[WIDTH]           one-hot grant, zero when idle
//   grant_index            binary index of the granted requester, zero when idle
//   grant_valid            grant presented; held until grant_valid & grant_ready
//   grant_ready            consumer accepts the grant
// Optional feature macro: ROUND_ROBIN_ARBITER_LOCK_EN
module round_robin_arbiter #(
  parameter int WIDTH = 4,
  localparam int INDEX_WIDTH = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       requests,
  input  logic                   grant_ready,
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  input  logic                   lock,
`endif
  output logic [WIDTH-1:0]       grant,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   grant_valid
);
  typedef enum logic {IDLE, GRANTED} state_t;
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(WIDTH - 1);
  state_t state, state_n;
  logic [INDEX_WIDTH-1:0] pointer, ptr_n, adv, found, win, idx_n;
  logic [WIDTH-1:0] rotated, grant_n;
  logic hs, keep, hit, valid_n;
  always_comb begin
    hs = grant_valid & grant_ready;
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
    keep = hs & lock & requests[grant_index];
`else
    keep = 1'b0;
`endif
    adv = grant_index == LAST ? '0 : grant_index + 1'b1;
    // arbitrate with the pointer as it will be after this edge, so a handshake re-grants without a bubble
    ptr_n = (hs && !keep) ? adv : pointer;
    rotated = '0;
    for (int i = 0; i < WIDTH; i++) rotated[i] = requests[(i + int'(ptr_n)) % WIDTH];
    found = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (rotated[i]) found = INDEX_WIDTH'(i);
    win = INDEX_WIDTH'((int'(found) + int'(ptr_n)) % WIDTH);
    hit = |requests;
    state_n = state;
    grant_n = grant;
    idx_n = grant_index;
    valid_n = grant_valid;
    if (state == IDLE || (hs && !keep)) begin
      state_n = hit ? GRANTED : IDLE;
      grant_n = hit ? WIDTH'(1) << win : '0;
      idx_n = hit ? win : '0;
      valid_n = hit;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pointer <= '0;
      grant <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
    end else begin
      state <= state_n;
      pointer <= ptr_n;
      grant <= grant_n;
      grant_index <= idx_n;
      grant_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed self-checking bench for round_robin_arbiter (WIDTH=4)
module tb_round_robin_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] requests = 4'b0000;
  logic grant_ready = 1'b0;
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  logic lock = 1'b0;
`endif
  logic [3:0] grant;
  logic [1:0] grant_index;
  logic grant_valid;
  logic [6:0] obs;
  logic [6:0] exp;
  int vectors = 0;
  int miscompares = 0;
  assign obs = {grant_valid, grant_index, grant};
  always #5 clock = ~clock;
  round_robin_arbiter #(.WIDTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .requests(requests),
    .grant_ready(grant_ready),
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
    .lock(lock),
`endif
    .grant(grant),
    .grant_index(grant_index),
    .grant_valid(grant_valid)
  );
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    requests = 4'b0000;
    step();
    vectors++;
    if (obs !== 7'b0) begin miscompares++; $display("FAIL reset_hold: got %b want %b", obs, 7'b0); end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if (obs !== 7'b0) begin miscompares++; $display("FAIL idle_%0d: got %b want %b", k, obs, 7'b0); end
    end
  endtask
  task automatic test_round_robin();
    requests = 4'b1111;
    grant_ready = 1'b1;
    #1;
    vectors++;
    if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL rr_latency: got %b want 0", grant_valid); end
    for (int k = 0; k < 8; k++) begin
      step();
      exp = {1'b1, 2'(k % 4), 4'(1 << (k % 4))};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL rr_%0d: got %b want %b", k, obs, exp); end
    end
    requests = 4'b0000;
    step();
    vectors++;
    if (obs !== 7'b0) begin miscompares++; $display("FAIL rr_drain: got %b want %b", obs, 7'b0); end
  endtask
  task automatic test_hold();
    requests = 4'b1010;
    grant_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (obs !== 7'b1_01_0010) begin miscompares++; $display("FAIL hold_%0d: got %b want %b", k, obs, 7'b1_01_0010); end
    end
    grant_ready = 1'b1;
    step();
    vectors++;
    if (obs !== 7'b1_11_1000) begin miscompares++; $display("FAIL hold_next: got %b want %b", obs, 7'b1_11_1000); end
    step();
    vectors++;
    if (obs !== 7'b1_01_0010) begin miscompares++; $display("FAIL hold_wrap: got %b want %b", obs, 7'b1_01_0010); end
    requests = 4'b0000;
    step();
    vectors++;
    if (obs !== 7'b0) begin miscompares++; $display("FAIL hold_drain: got %b want %b", obs, 7'b0); end
  endtask
  task automatic test_sticky();
    requests = 4'b0100;
    grant_ready = 1'b0;
    step();
    vectors++;
    if (obs !== 7'b1_10_0100) begin miscompares++; $display("FAIL sticky_grant: got %b want %b", obs, 7'b1_10_0100); end
    requests = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (obs !== 7'b1_10_0100) begin miscompares++; $display("FAIL sticky_hold_%0d: got %b want %b", k, obs, 7'b1_10_0100); end
    end
    grant_ready = 1'b1;
    step();
    vectors++;
    if (obs !== 7'b1_00_0001) begin miscompares++; $display("FAIL sticky_next: got %b want %b", obs, 7'b1_00_0001); end
    requests = 4'b0010;
    step();
    vectors++;
    if (obs !== 7'b1_01_0010) begin miscompares++; $display("FAIL b2b_1: got %b want %b", obs, 7'b1_01_0010); end
    requests = 4'b0100;
    step();
    vectors++;
    if (obs !== 7'b1_10_0100) begin miscompares++; $display("FAIL b2b_2: got %b want %b", obs, 7'b1_10_0100); end
    grant_ready = 1'b0;
  endtask
  task automatic test_reset_mid();
    requests = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 7'b0) begin miscompares++; $display("FAIL async_clear: got %b want %b", obs, 7'b0); end
    step();
    vectors++;
    if (obs !== 7'b0) begin miscompares++; $display("FAIL reset_held: got %b want %b", obs, 7'b0); end
    reset = 1'b0;
    grant_ready = 1'b1;
    step();
    vectors++;
    if (obs !== 7'b1_00_0001) begin miscompares++; $display("FAIL post_reset_0: got %b want %b", obs, 7'b1_00_0001); end
    step();
    vectors++;
    if (obs !== 7'b1_01_0010) begin miscompares++; $display("FAIL post_reset_1: got %b want %b", obs, 7'b1_01_0010); end
    requests = 4'b0000;
    step();
    vectors++;
    if (obs !== 7'b0) begin miscompares++; $display("FAIL post_reset_drain: got %b want %b", obs, 7'b0); end
  endtask
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  task automatic test_lock();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    requests = 4'b0110;
    lock = 1'b1;
    grant_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (obs !== 7'b1_01_0010) begin miscompares++; $display("FAIL lock_%0d: got %b want %b", k, obs, 7'b1_01_0010); end
    end
    lock = 1'b0;
    step();
    vectors++;
    if (obs !== 7'b1_10_0100) begin miscompares++; $display("FAIL lock_release: got %b want %b", obs, 7'b1_10_0100); end
    lock = 1'b1;
    requests = 4'b0010;
    step();
    vectors++;
    if (obs !== 7'b1_01_0010) begin miscompares++; $display("FAIL lock_owner_gone: got %b want %b", obs, 7'b1_01_0010); end
    lock = 1'b0;
    requests = 4'b0000;
    step();
    vectors++;
    if (obs !== 7'b0) begin miscompares++; $display("FAIL lock_drain: got %b want %b", obs, 7'b0); end
  endtask
`endif
  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_sticky();
    test_reset_mid();
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/round_robin_arbiter.md
Name: round_robin_arbiter

Overview:
- Sequential round-robin arbiter sharing one downstream resource (e.g. a shared rotator/shifter datapath port) among WIDTH requesters.
- Priority is rotated by rotating the request vector right by a registered pointer, priority-encoding the result, then mapping the winner back.
- The grant is registered and held stable under a valid/ready handshake with the consumer. The pointer advances past the winner only on handshake.

Parameters:
- WIDTH, 4, number of requesters (>=1).
- INDEX_WIDTH, derived localparam = max(1, clog2(WIDTH)), width of the grant index.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- requests  input  WIDTH  per-requester request level; bit i = requester i.
- grant  output  WIDTH  one-hot registered grant; all zero when grant_valid=0.
- grant_index  output  INDEX_WIDTH  binary index of the granted requester; 0 when grant_valid=0.
- grant_valid  output  1  a grant is presented.
- grant_ready  input  1  consumer accepts the grant; handshake = grant_valid & grant_ready.

Behaviour:
- Reset (async, any time, including mid-grant):
  - grant=0, grant_index=0, grant_valid=0, pointer=0, state=IDLE.
  - All outputs are registered, so they change only on clock edges or reset assertion.
- Arbitration function (combinational):
  - Rotate requests right by pointer.
  - Lowest set bit wins.
  - winner = (found_position + pointer) mod WIDTH.
  - With pointer=p, priority order is p, p+1, …, WIDTH-1, 0, …, p-1.
- State IDLE:
  - If requests != 0: register grant=onehot(winner), grant_index=winner, grant_valid=1; go to GRANTED.
  - Latency is 1 cycle from request to grant_valid.
  - If requests == 0: stay in IDLE.
- State GRANTED:
  - grant, grant_index and grant_valid are held stable until handshake.
  - This holds even if the granted requester or any other requester drops its request (sticky grant, no retraction).
- On handshake:
  - pointer <= (grant_index+1) mod WIDTH.
  - In the same edge, re-arbitrate the current requests using the updated pointer value (back-to-back, no bubble).
  - If any request is present: load the new grant and stay in GRANTED.
  - Otherwise: clear the grant and go to IDLE.
- Throughput: one grant per cycle when grant_ready is held high and requests are continuous.
- Pointer wrap: when grant_index = WIDTH-1, pointer wraps to 0.
- WIDTH=1: grant=requests registered; pointer is always 0; grant_index=0.
- Fairness: with all requesters continuously requesting and grant_ready=1, each requester is granted exactly once every WIDTH handshakes.
- Pointer width is INDEX_WIDTH. Modulo arithmetic must be correct for non-power-of-two WIDTH.

Optional Feature:
- Macro: ROUND_ROBIN_ARBITER_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - If a handshake occurs with lock=1 and requests[grant_index]=1, the same grant is reissued.
  - In that case the pointer is not advanced (burst ownership).
  - If lock=1 but the owner has dropped its request, normal arbitration applies.
- When undefined:
  - No lock port.
  - Every handshake advances the pointer as above.

Test Plan:
- Reset, then requests=4'b0000 for 5 cycles -> grant_valid=0, grant=0, grant_index=0 throughout.
- requests=4'b1111, grant_ready=1 continuously -> grants 0,1,2,3,0,… one per cycle; first grant_valid 1 cycle after requests.
- requests=4'b1010, grant_ready=0 for 3 cycles then 1 -> grant=4'b0010 held stable 4 cycles; after handshake grant=4'b1000, grant_index=3; next handshake wraps and grants 1 again.
- Grant to requester 2 with grant_ready=0, then requests drops to 4'b0001 -> grant stays 4'b0100 until handshake; next grant=4'b0001.
- Assert reset mid-GRANTED (grant=4'b0100, pointer=2) -> outputs cleared immediately; after release with requests=4'b1111, first grant is 0.
- LOCK_EN: requests=4'b0110, lock=1, grant_ready=1 -> grant 4'b0010 repeats; lock=0 -> next grant 4'b0100.
